// File: rtl/mmio_router.sv
// Single-outstanding data-side bus router: decodes RAM / ACLINT / unmapped and returns one response
// per accepted request. Optional fault reporting is enabled by defining MMIO_ROUTER_FAULT_EN.
module mmio_router #(
  parameter logic [63:0] ACLINT_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] ACLINT_SIZE = 64'h0000_0000_0001_0000,
  parameter logic [63:0] RAM_BASE    = 64'h0000_0000_8000_0000,
  parameter logic [63:0] RAM_SIZE    = 64'h0000_0000_1000_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        up_valid,
  output logic        up_ready,
  input  logic [63:0] up_addr,
  input  logic        up_wen,
  input  logic [63:0] up_wdata,
  input  logic [7:0]  up_wmask,
  output logic        up_rvalid,
  output logic [63:0] up_rdata,

  output logic        ram_valid,
  input  logic        ram_ready,
  output logic [63:0] ram_addr,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  input  logic        ram_rvalid,
  input  logic [63:0] ram_rdata,

  output logic        acl_valid,
  input  logic        acl_ready,
  output logic [63:0] acl_addr,
  output logic        acl_wen,
  output logic [63:0] acl_wdata,
  output logic [7:0]  acl_wmask,
  input  logic        acl_rvalid,
  input  logic [63:0] acl_rdata,

  output logic        fault,
  output logic [63:0] fault_addr
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
  typedef enum logic [1:0] {TgtRam, TgtAcl, TgtNone} tgt_e;

  state_e      state_q, state_d;
  tgt_e        tgt_q, dec_tgt;
  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        accept;

  // ACLINT is checked first so it wins if the regions overlap.
  always_comb begin
    dec_tgt = TgtNone;
    if ((up_addr & ~(ACLINT_SIZE - 64'd1)) == ACLINT_BASE) begin
      dec_tgt = TgtAcl;
    end else if ((up_addr & ~(RAM_SIZE - 64'd1)) == RAM_BASE) begin
      dec_tgt = TgtRam;
    end
  end

  assign up_ready = (state_q == StIdle);
  assign accept   = up_valid & up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tgt_q   <= TgtNone;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tgt_q   <= dec_tgt;
        addr_q  <= up_addr;
        wen_q   <= up_wen;
        wdata_q <= up_wdata;
        wmask_q <= up_wmask;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_valid = 1'b0;
    acl_valid = 1'b0;
    up_rvalid = 1'b0;
    up_rdata  = 64'd0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        unique case (tgt_q)
          TgtRam: begin
            ram_valid = 1'b1;
            if (ram_ready) state_d = StResp;
          end
          TgtAcl: begin
            acl_valid = 1'b1;
            if (acl_ready) state_d = StResp;
          end
          default: state_d = StResp;
        endcase
      end
      StResp: begin
        // Only the selected target's rvalid is honoured; others are dropped.
        unique case (tgt_q)
          TgtRam: begin
            if (ram_rvalid) begin
              up_rvalid = 1'b1;
              up_rdata  = ram_rdata;
              state_d   = StIdle;
            end
          end
          TgtAcl: begin
            if (acl_rvalid) begin
              up_rvalid = 1'b1;
              up_rdata  = acl_rdata;
              state_d   = StIdle;
            end
          end
          default: begin
            up_rvalid = 1'b1;
            state_d   = StIdle;
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  assign ram_addr  = addr_q;
  assign ram_wen   = wen_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;
  assign acl_addr  = addr_q;
  assign acl_wen   = wen_q;
  assign acl_wdata = wdata_q;
  assign acl_wmask = wmask_q;

`ifdef MMIO_ROUTER_FAULT_EN
  logic [63:0] fault_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_addr_q <= 64'd0;
    end else if (accept && (dec_tgt == TgtNone)) begin
      fault_addr_q <= up_addr;
    end
  end

  // Unmapped ISSUE lasts exactly one cycle, giving a single-cycle pulse.
  assign fault      = (state_q == StIssue) && (tgt_q == TgtNone);
  assign fault_addr = fault_addr_q;
`else
  assign fault      = 1'b0;
  assign fault_addr = 64'd0;
`endif

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: behavioural RAM/ACLINT responders plus a response scoreboard.
module tb_mmio_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid, up_ready, up_wen, up_rvalid;
  logic [63:0] up_addr, up_wdata, up_rdata;
  logic [7:0]  up_wmask;
  logic        ram_valid, ram_ready, ram_wen, ram_rvalid;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  ram_wmask;
  logic        acl_valid, acl_ready, acl_wen, acl_rvalid;
  logic [63:0] acl_addr, acl_wdata, acl_rdata;
  logic [7:0]  acl_wmask;
  logic        fault;
  logic [63:0] fault_addr;

  mmio_router dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_wen(up_wen),
    .up_wdata(up_wdata), .up_wmask(up_wmask), .up_rvalid(up_rvalid), .up_rdata(up_rdata),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_addr(ram_addr), .ram_wen(ram_wen),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata),
    .acl_valid(acl_valid), .acl_ready(acl_ready), .acl_addr(acl_addr), .acl_wen(acl_wen),
    .acl_wdata(acl_wdata), .acl_wmask(acl_wmask), .acl_rvalid(acl_rvalid),
    .acl_rdata(acl_rdata),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  logic [63:0] exp_q[$];

  // Responder state and bench-controlled knobs.
  logic [63:0] acl_data, ram_data;
  int unsigned ram_stall;
  int unsigned ram_vcnt;
  logic        acl_rv_m, ram_rv_m, spur_acl, spur_ram;

  assign acl_ready  = 1'b1;
  assign ram_ready  = (ram_vcnt >= ram_stall);
  assign acl_rvalid = acl_rv_m | spur_acl;
  assign ram_rvalid = ram_rv_m | spur_ram;
  assign acl_rdata  = acl_data;
  assign ram_rdata  = ram_data;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acl_rv_m <= acl_valid && acl_ready;
    ram_rv_m <= ram_valid && ram_ready;
    ram_vcnt <= ram_valid ? ram_vcnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: every upstream response must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && up_rvalid) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", {63'd0, up_rvalid}, 64'd0);
      else check("rdata", up_rdata, exp_q.pop_front());
    end
  end

  // Present a request, push its expected response and return just after the accepting edge.
  task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] m, input logic [63:0] exp_rd);
    int budget = 50;
    @(negedge clk);
    up_addr = a; up_wen = w; up_wdata = d; up_wmask = m; up_valid = 1'b1;
    while (!up_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("accept_timeout", {63'd0, up_ready}, 64'd1);
    exp_q.push_back(exp_rd);
    @(posedge clk);
    #1 up_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  int unsigned acc_cyc[3];
  int unsigned accepts, vcycles, rv_seen;

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_addr = '0; up_wen = 1'b0; up_wdata = '0; up_wmask = '0;
    acl_data = 64'h1234; ram_data = 64'hDEAD_BEEF_0000_0001; ram_stall = 0;
    spur_acl = 1'b0; spur_ram = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_up_ready", {63'd0, up_ready}, 64'd1);
    check("rst_up_rvalid", {63'd0, up_rvalid}, 64'd0);
    check("rst_up_rdata", up_rdata, 64'd0);
    check("rst_valids", {62'd0, ram_valid, acl_valid}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);
    check("rst_fault_addr", fault_addr, 64'd0);
    rst = 1'b0;

    // ACLINT mtime read.
    do_req(64'h0000_0000_0200_BFF8, 1'b0, 64'd0, 8'hFF, 64'h1234);
    @(negedge clk);
    check("acl_t1_valid", {62'd0, acl_valid, ram_valid}, 64'd2);
    check("acl_t1_addr", acl_addr, 64'h0000_0000_0200_BFF8);
    check("acl_t1_rvalid", {63'd0, up_rvalid}, 64'd0);
    @(negedge clk);
    check("acl_t2_valid", {62'd0, acl_valid, ram_valid}, 64'd0);
    check("acl_t2_rvalid", {63'd0, up_rvalid}, 64'd1);
    @(negedge clk);
    check("acl_t3_ready", {63'd0, up_ready}, 64'd1);
    drain("acl_drain");

    // RAM write with 3 stall cycles.
    ram_stall = 3;
    do_req(64'h0000_0000_8000_0010, 1'b1, 64'h0BAD_F00D_CAFE_0042, 8'h0F, ram_data);
    vcycles = 0; rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ram_valid) begin
        vcycles++;
        check("ram_addr", ram_addr, 64'h0000_0000_8000_0010);
        check("ram_fields", {ram_wdata[54:0], ram_wen, ram_wmask},
              {55'(64'h0BAD_F00D_CAFE_0042), 1'b1, 8'h0F});
        check("ram_acl_quiet", {63'd0, acl_valid}, 64'd0);
      end
      if (up_rvalid) rv_seen++;
      if (rv_seen == 0) check("ram_up_ready_low", {63'd0, up_ready}, 64'd0);
    end
    check("ram_valid_cycles", 64'(vcycles), 64'd4);
    check("ram_rvalid_count", 64'(rv_seen), 64'd1);
    ram_stall = 0;
    drain("ram_drain");

    // Unmapped read.
    do_req(64'h0000_0000_4000_0000, 1'b0, 64'd0, 8'hFF, 64'd0);
    @(negedge clk);
    check("unm_t1_rvalid", {63'd0, up_rvalid}, 64'd0);
    check("unm_t1_valids", {62'd0, ram_valid, acl_valid}, 64'd0);
`ifdef MMIO_ROUTER_FAULT_EN
    check("unm_t1_fault", {63'd0, fault}, 64'd1);
`else
    check("unm_t1_fault", {63'd0, fault}, 64'd0);
`endif
    @(negedge clk);
    check("unm_t2_rvalid", {63'd0, up_rvalid}, 64'd1);
    check("unm_t2_fault", {63'd0, fault}, 64'd0);
`ifdef MMIO_ROUTER_FAULT_EN
    check("unm_fault_addr", fault_addr, 64'h0000_0000_4000_0000);
`else
    check("unm_fault_addr", fault_addr, 64'd0);
`endif
    drain("unm_drain");

    // Spurious rvalids: ACLINT while idle, RAM during an ACLINT transaction.
    @(negedge clk);
    spur_acl = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_idle_rvalid", {63'd0, up_rvalid}, 64'd0);
    end
    spur_acl = 1'b0;
    acl_data = 64'h5555_AAAA_0000_7777;
    do_req(64'h0000_0000_0200_4000, 1'b0, 64'd0, 8'hFF, 64'h5555_AAAA_0000_7777);
    spur_ram = 1'b1;
    @(negedge clk);
    check("spur_t1_rvalid", {63'd0, up_rvalid}, 64'd0);
    @(negedge clk);
    check("spur_t2_rdata", up_rdata, 64'h5555_AAAA_0000_7777);
    spur_ram = 1'b0;
    drain("spur_drain");

    // Back-to-back ACLINT requests with up_valid held high.
    @(negedge clk);
    acl_data = 64'h0000_0000_00B2_B000;
    up_addr = 64'h0000_0000_0200_0008; up_wen = 1'b0; up_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 30 && accepts < 3; i++) begin
      if (i != 0) @(negedge clk);
      if (up_ready) begin
        exp_q.push_back(64'h0000_0000_00B2_B000);
        acc_cyc[accepts] = cyc;
        accepts++;
      end
    end
    @(posedge clk);
    #1 up_valid = 1'b0;
    @(negedge clk);
    check("b2b_ready_busy", {63'd0, up_ready}, 64'd0);
    check("b2b_accepts", 64'(accepts), 64'd3);
    check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    drain("b2b_drain");

    // Reset during RAM ISSUE, then a late ram_rvalid.
    ram_stall = 5;
    do_req(64'h0000_0000_8000_0100, 1'b0, 64'd0, 8'hFF, ram_data);
    @(negedge clk);
    check("rst_mid_issue", {63'd0, ram_valid}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_valids", {62'd0, ram_valid, acl_valid}, 64'd0);
    check("rst_mid_ready", {63'd0, up_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    ram_stall = 0;
    spur_ram = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_late_rvalid", {63'd0, up_rvalid}, 64'd0);
      check("rst_late_valids", {62'd0, ram_valid, acl_valid}, 64'd0);
    end
    spur_ram = 1'b0;
    repeat (2) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
